// File: rtl/seq_det_ctrl.sv
// -----------------------------------------------------------------------------
// seq_det_ctrl
//   Configurable serial pattern detector with a small run-control FSM.
//   A pattern (up to PW bits, MSB of the used field first) is loaded through a
//   valid/ready config port, a run is launched with start, and every x_valid
//   sample is shifted into a history register and compared against the pattern.
//   Matches raise a one-cycle y pulse and bump a saturating match counter; a
//   non-zero target ends the run in DONE once that many matches are seen.
//
// Ports
//   clk, rst       : clock, asynchronous active-high reset
//   cfg_valid/ready: config handshake (ready low only while a run is active)
//   cfg_pattern    : pattern bits, cfg_pattern[len-1] is the first bit expected
//   cfg_len        : pattern length, legal 1..PW
//   cfg_overlap    : 1 = overlapping matches, 0 = history cleared after a match
//   cfg_target     : match count that ends the run, 0 = run forever
//   start, abort   : run launch / run termination
//   x, x_valid     : serial data and its qualifier
//   y              : registered one-cycle match pulse
//   match_count    : saturating match count of the current run
//   busy, done     : in RUN / in DONE
//   cfg_err        : one-cycle pulse after a rejected configuration
// -----------------------------------------------------------------------------
module seq_det_ctrl #(
    parameter int PW = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [PW-1:0] cfg_pattern,
    input  logic [3:0]    cfg_len,
    input  logic          cfg_overlap,
    input  logic [CW-1:0] cfg_target,
    input  logic          start,
    input  logic          abort,
    input  logic          x,
    input  logic          x_valid,
    output logic          y,
    output logic [CW-1:0] match_count,
    output logic          busy,
    output logic          done,
    output logic          cfg_err
);

    localparam int FW = $clog2(PW + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pat_q, pat_d;
    logic [3:0]    len_q, len_d;
    logic          ovl_q, ovl_d;
    logic [CW-1:0] tgt_q, tgt_d;
    logic [PW-1:0] hist_q, hist_d;
    logic [FW-1:0] fill_q, fill_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          y_q, y_d;
    logic          cfg_err_q, cfg_err_d;

    logic          cfg_fire_s;
    logic          cfg_ok_s;
    logic          start_ok_s;
    logic          sample_s;
    logic [PW-1:0] hist_shift_s;
    logic [FW-1:0] fill_inc_s;
    logic [PW-1:0] mask_s;
    logic          hit_s;
    logic [CW-1:0] cnt_inc_s;
    logic          reach_s;

    // Shared decode: handshake, legality, sample qualification and match test.
    always_comb begin
        cfg_fire_s   = cfg_valid && (state_q != S_RUN);
        cfg_ok_s     = (cfg_len != 4'd0) && (32'(cfg_len) <= PW);
        // A config handshake in the same cycle wins over start.
        start_ok_s   = start && !cfg_fire_s && ((state_q == S_ARMED) || (state_q == S_DONE));
        // Abort suppresses the sample of its own cycle, so it can never produce y.
        sample_s     = (state_q == S_RUN) && x_valid && !abort;
        hist_shift_s = {hist_q[PW-2:0], x};
        fill_inc_s   = (32'(fill_q) >= PW) ? fill_q : (fill_q + FW'(1));
        mask_s       = ~({PW{1'b1}} << len_q);
        hit_s        = sample_s && (32'(fill_inc_s) >= 32'(len_q)) &&
                       (((hist_shift_s ^ pat_q) & mask_s) == {PW{1'b0}});
        cnt_inc_s    = (cnt_q == {CW{1'b1}}) ? cnt_q : (cnt_q + CW'(1));
        reach_s      = hit_s && (tgt_q != {CW{1'b0}}) && (cnt_inc_s == tgt_q);
    end

    // State register plus all datapath flops; reset clears everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pat_q     <= {PW{1'b0}};
            len_q     <= 4'd0;
            ovl_q     <= 1'b0;
            tgt_q     <= {CW{1'b0}};
            hist_q    <= {PW{1'b0}};
            fill_q    <= {FW{1'b0}};
            cnt_q     <= {CW{1'b0}};
            y_q       <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            ovl_q     <= ovl_d;
            tgt_q     <= tgt_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            cnt_q     <= cnt_d;
            y_q       <= y_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // Next-state logic of the run-control FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cfg_fire_s && cfg_ok_s) state_d = S_ARMED;
                else                        state_d = S_IDLE;
            end
            S_ARMED, S_DONE: begin
                if (cfg_fire_s && cfg_ok_s) state_d = S_ARMED;
                else if (start_ok_s)        state_d = S_RUN;
                else                        state_d = state_q;
            end
            S_RUN: begin
                if (abort)        state_d = S_ARMED;
                else if (reach_s) state_d = S_DONE;
                else              state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: config latch, run init, sampling and matching.
    always_comb begin
        pat_d     = pat_q;
        len_d     = len_q;
        ovl_d     = ovl_q;
        tgt_d     = tgt_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        cnt_d     = cnt_q;
        y_d       = 1'b0;
        cfg_err_d = cfg_fire_s && !cfg_ok_s;
        if (cfg_fire_s && cfg_ok_s) begin
            pat_d = cfg_pattern;
            len_d = cfg_len;
            ovl_d = cfg_overlap;
            tgt_d = cfg_target;
        end else begin
            pat_d = pat_q;
        end
        if (start_ok_s) begin
            hist_d = {PW{1'b0}};
            fill_d = {FW{1'b0}};
            cnt_d  = {CW{1'b0}};
        end else if (sample_s) begin
            hist_d = hist_shift_s;
            // Non-overlapping mode restarts the fill so old bits cannot be reused.
            fill_d = (hit_s && !ovl_q) ? {FW{1'b0}} : fill_inc_s;
            if (hit_s) begin
                y_d   = 1'b1;
                cnt_d = cnt_inc_s;
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            hist_d = hist_q;
        end
    end

    // Output decode from registered state and flops.
    always_comb begin
        cfg_ready   = (state_q != S_RUN);
        busy        = (state_q == S_RUN);
        done        = (state_q == S_DONE);
        y           = y_q;
        match_count = cnt_q;
        cfg_err     = cfg_err_q;
    end

endmodule

// File: tb/tb_seq_det_ctrl.sv
module tb_seq_det_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic [7:0] cfg_target;
    logic       start;
    logic       abort;
    logic       x;
    logic       x_valid;
    logic       y;
    logic [7:0] match_count;
    logic       busy;
    logic       done;
    logic       cfg_err;

    int errors = 0;
    int checks = 0;

    // expected flag bits {y, busy, done, cfg_err, cfg_ready}
    localparam logic [4:0] F_Y = 5'b10000;
    localparam logic [4:0] F_B = 5'b01000;
    localparam logic [4:0] F_D = 5'b00100;
    localparam logic [4:0] F_E = 5'b00010;
    localparam logic [4:0] F_R = 5'b00001;

    typedef struct {
        logic       cv;
        logic [7:0] pat;
        logic [3:0] len;
        logic       ovl;
        logic [7:0] tgt;
        logic       st;
        logic       ab;
        logic       xv;
        logic       xb;
        logic [4:0] ef;
        logic [7:0] ec;
    } vec_t;

    vec_t vq[$];

    seq_det_ctrl #(.PW(8), .CW(8)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cfg_target(cfg_target),
        .start(start), .abort(abort), .x(x), .x_valid(x_valid),
        .y(y), .match_count(match_count), .busy(busy), .done(done),
        .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic cv, input logic [7:0] pat, input logic [3:0] len,
                                input logic ovl, input logic [7:0] tgt, input logic st,
                                input logic ab, input logic xv, input logic xb,
                                input logic [4:0] ef, input logic [7:0] ec);
        vec_t v;
        v.cv = cv; v.pat = pat; v.len = len; v.ovl = ovl; v.tgt = tgt;
        v.st = st; v.ab = ab; v.xv = xv; v.xb = xb; v.ef = ef; v.ec = ec;
        return v;
    endfunction

    function automatic vec_t cfgv(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                                  input logic [7:0] tgt, input logic [4:0] ef, input logic [7:0] ec);
        return mk(1'b1, pat, len, ovl, tgt, 1'b0, 1'b0, 1'b0, 1'b0, ef, ec);
    endfunction

    function automatic vec_t ctl(input logic st, input logic ab, input logic [4:0] ef, input logic [7:0] ec);
        return mk(1'b0, 8'h00, 4'd0, 1'b0, 8'd0, st, ab, 1'b0, 1'b0, ef, ec);
    endfunction

    function automatic vec_t smp(input logic xb, input logic [4:0] ef, input logic [7:0] ec);
        return mk(1'b0, 8'h00, 4'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, xb, ef, ec);
    endfunction

    function automatic logic [12:0] obs();
        return {y, busy, done, cfg_err, cfg_ready, match_count};
    endfunction

    task automatic chk(input string name, input logic [12:0] act, input logic [12:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: {y,busy,done,cfg_err,cfg_ready}=%b cnt=%0d, expected %b cnt=%0d",
                     name, act[12:8], act[7:0], exp[12:8], exp[7:0]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_pattern = 8'h00; cfg_len = 4'd0;
        cfg_overlap = 1'b0; cfg_target = 8'd0; start = 1'b0; abort = 1'b0;
        x = 1'b0; x_valid = 1'b0;

        // Overlap: 101 in 0,1,1,1,0,1,0,1 -> y after samples 6 and 8
        vq.push_back(cfgv(8'h05, 4'd3, 1'b1, 8'd0, F_R, 8'd0));
        vq.push_back(ctl(1'b1, 1'b0, F_B, 8'd0));
        vq.push_back(smp(1'b0, F_B, 8'd0));
        vq.push_back(smp(1'b1, F_B, 8'd0));
        vq.push_back(smp(1'b1, F_B, 8'd0));
        vq.push_back(smp(1'b1, F_B, 8'd0));
        vq.push_back(smp(1'b0, F_B, 8'd0));
        vq.push_back(smp(1'b1, F_Y | F_B, 8'd1));
        vq.push_back(smp(1'b0, F_B, 8'd1));
        vq.push_back(smp(1'b1, F_Y | F_B, 8'd2));
        vq.push_back(ctl(1'b0, 1'b0, F_B, 8'd2));
        vq.push_back(ctl(1'b0, 1'b1, F_R, 8'd2));
        // Non-overlap: 1,0,1,0,1 -> one match after sample 3
        vq.push_back(cfgv(8'h05, 4'd3, 1'b0, 8'd0, F_R, 8'd2));
        vq.push_back(ctl(1'b1, 1'b0, F_B, 8'd0));
        vq.push_back(smp(1'b1, F_B, 8'd0));
        vq.push_back(smp(1'b0, F_B, 8'd0));
        vq.push_back(smp(1'b1, F_Y | F_B, 8'd1));
        vq.push_back(smp(1'b0, F_B, 8'd1));
        vq.push_back(smp(1'b1, F_B, 8'd1));
        vq.push_back(ctl(1'b0, 1'b1, F_R, 8'd1));
        // Target 2: DONE on the edge of the second match, later samples ignored
        vq.push_back(cfgv(8'h05, 4'd3, 1'b1, 8'd2, F_R, 8'd1));
        vq.push_back(ctl(1'b1, 1'b0, F_B, 8'd0));
        vq.push_back(smp(1'b1, F_B, 8'd0));
        vq.push_back(smp(1'b0, F_B, 8'd0));
        vq.push_back(smp(1'b1, F_Y | F_B, 8'd1));
        vq.push_back(smp(1'b0, F_B, 8'd1));
        vq.push_back(smp(1'b1, F_Y | F_D | F_R, 8'd2));
        vq.push_back(smp(1'b0, F_D | F_R, 8'd2));
        vq.push_back(smp(1'b1, F_D | F_R, 8'd2));
        // Illegal configs (len 0, len 9) keep pattern 110
        vq.push_back(cfgv(8'h06, 4'd3, 1'b0, 8'd0, F_R, 8'd2));
        vq.push_back(cfgv(8'h03, 4'd0, 1'b1, 8'd5, F_R | F_E, 8'd2));
        vq.push_back(cfgv(8'h0F, 4'd9, 1'b1, 8'd5, F_R | F_E, 8'd2));
        vq.push_back(ctl(1'b1, 1'b0, F_B, 8'd0));
        vq.push_back(smp(1'b0, F_B, 8'd0));
        vq.push_back(smp(1'b1, F_B, 8'd0));
        vq.push_back(smp(1'b1, F_B, 8'd0));
        vq.push_back(smp(1'b0, F_Y | F_B, 8'd1));

        #12;
        chk("reset_state", obs(), {F_R, 8'd0});
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("idle_after_reset", obs(), {F_R, 8'd0});
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_in_idle_ignored", obs(), {F_R, 8'd0});

        for (int i = 0; i < vq.size(); i++) begin
            cfg_valid = vq[i].cv; cfg_pattern = vq[i].pat; cfg_len = vq[i].len;
            cfg_overlap = vq[i].ovl; cfg_target = vq[i].tgt; start = vq[i].st;
            abort = vq[i].ab; x_valid = vq[i].xv; x = vq[i].xb;
            tick();
            chk($sformatf("vec%0d", i), obs(), {vq[i].ef, vq[i].ec});
        end
        cfg_valid = 1'b0; start = 1'b0; abort = 1'b0; x_valid = 1'b0; x = 1'b0;

        // Gaps between bits of 101, then abort on the completing sample
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_to_armed", obs(), {F_R, 8'd1});
        cfg_valid = 1'b1; cfg_pattern = 8'h05; cfg_len = 4'd3; cfg_overlap = 1'b1; cfg_target = 8'd0;
        tick(); cfg_valid = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        x = 1'b1; x_valid = 1'b1; tick();
        x = 1'b0; x_valid = 1'b0; tick();
        x = 1'b1; x_valid = 1'b0; tick();
        x = 1'b0; x_valid = 1'b1; tick();
        x_valid = 1'b0; tick();
        x = 1'b1; x_valid = 1'b1; tick();
        chk("gap_match", obs(), {F_Y | F_B, 8'd1});
        x_valid = 1'b0; tick();
        chk("gap_pulse_one_cycle", obs(), {F_B, 8'd1});
        x = 1'b0; x_valid = 1'b1; tick();
        x = 1'b1; abort = 1'b1; tick();
        abort = 1'b0; x_valid = 1'b0;
        chk("abort_on_match", obs(), {F_R, 8'd1});
        tick();
        chk("abort_no_late_y", obs(), {F_R, 8'd1});

        // Config and start together: config wins, stays ARMED
        cfg_valid = 1'b1; start = 1'b1; cfg_pattern = 8'h01; cfg_len = 4'd1;
        tick(); cfg_valid = 1'b0; start = 1'b0;
        chk("cfg_start_same_cycle", obs(), {F_R, 8'd1});
        start = 1'b1; tick(); start = 1'b0;
        chk("start_after_cfg", obs(), {F_B, 8'd0});

        // Counter saturation with a 1-bit pattern matching every sample
        x = 1'b1; x_valid = 1'b1;
        for (int i = 0; i < 260; i++) tick();
        chk("count_saturates", obs(), {F_Y | F_B, 8'hFF});

        // Asynchronous reset between edges while y is high
        #2 rst = 1'b1;
        #1;
        chk("async_reset", obs(), {F_R, 8'd0});
        x_valid = 1'b0; x = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        chk("start_needs_new_cfg", obs(), {F_R, 8'd0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
